div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
Shares one div_unsigned divider among NUM_REQ requesters, e.g. gaussian_blur normalisation lanes and hough accumulator scaling. Round-robin grant with a valid/ready request handshake and a one-cycle response pulse tagged with the requester ID. Divide-by-zero is intercepted locally and never reaches the divider. Sits between the image-processing stages and a single divider instance owned by this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DIVIDEND_WIDTH, 16, dividend/quotient width, passed to the divider
DIVISOR_WIDTH, 8, divisor width, passed to the divider
ID_WIDTH, $clog2(NUM_REQ), requester ID width (localparam)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_dividend  in  NUM_REQ*DIVIDEND_WIDTH  packed dividends; slice i belongs to requester i
req_divisor  in  NUM_REQ*DIVISOR_WIDTH  packed divisors
resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to the owning requester
resp_id  out  ID_WIDTH  ID of the responding requester
resp_quotient  out  DIVIDEND_WIDTH  result
resp_div0  out  1  high with resp_valid when the divisor was 0
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous, reset==0:
  - State goes to IDLE; rr pointer to 0; operand, ID and quotient registers cleared.
  - resp_valid, resp_div0 and busy are 0; resp_id and resp_quotient are 0.
  - The divider instance receives the inverted reset (it is active-high).
  - A transaction in flight is dropped; no response is ever issued for it.
- Arbitration (combinational):
  - grant = first set bit of req_valid, searching from rr_ptr upward with wrap-around.
  - req_ready[i] = (state==IDLE) && grant[i]. It is 0 in every other state.
  - A handshake is req_valid[i] && req_ready[i].
  - On a handshake: latch dividend/divisor slice i and the ID; rr_ptr <= (i+1) mod NUM_REQ.
  - rr_ptr changes only on a handshake.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: on a handshake with latched divisor != 0, go to ISSUE. With divisor == 0, go to RESP with div0_r=1 and quotient_r = all ones. Otherwise stay.
  - ISSUE: drive divider valid_in=1 with the latched operands for exactly this one cycle, then go to WAIT.
  - WAIT: valid_in=0. On divider valid_out, capture the quotient and go to RESP. No timeout.
  - RESP: resp_valid[id]=1, resp_id=id, resp_quotient=quotient_r, resp_div0=div0_r for exactly one cycle, then go to IDLE.
- resp_quotient, resp_id and resp_div0 are don't-care outside RESP. They are driven from registers and hold their last values.
- Latency, handshake cycle = cycle 0:
  - divisor==1: ISSUE at cycle 1, divider valid_out at cycle 2, resp_valid at cycle 3.
  - Any divisor >= 2: resp_valid one cycle after divider valid_out.
  - divisor==0: resp_valid at cycle 1; divider untouched.
- Throughput: one division in flight. The next handshake can occur in the IDLE cycle right after RESP, so there is 1 idle cycle minimum between responses.
- Requesters may change operands or drop req_valid freely after their handshake; latched values are used.
- A requester keeping req_valid high is not re-granted while others wait, by round-robin rotation.
- NUM_REQ == 1 reduces to a pass-through sequencer; rr_ptr stays 0.
- Width rules:
  - The quotient is DIVIDEND_WIDTH, unsigned, with no truncation.
  - Divisor values are zero-extended inside the divider.

Decomposition:
- Package div_arb_pkg: state_t enum {IDLE, ISSUE, WAIT, RESP}; DIV0_QUOTIENT all-ones constant function of width.
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr; output one-hot grant and encoded index. Purely combinational, reusable elsewhere.
- One div_unsigned instance inside this block, with parameters passed through.

Test Plan:
- Single request: req_valid=0001, dividend=100, divisor=7 -> resp_valid=0001, resp_id=0, resp_quotient=14, resp_div0=0; req_ready low until the resp cycle has passed.
- Divisor 1 latency: req 2, dividend=0xBEEF, divisor=1 -> resp_valid=0100 exactly 3 cycles after the handshake, quotient=0xBEEF.
- Divide-by-zero: req 3, dividend=55, divisor=0 -> resp 1 cycle after the handshake, quotient=0xFFFF, resp_div0=1, divider valid_in never asserted.
- Round-robin fairness: all four req_valid held high, divisor=3, dividend=30 -> grant order 0,1,2,3,0; each quotient=10; no requester granted twice in any 4 consecutive grants.
- Reset mid-operation: assert reset=0 during WAIT of a 65535/2 division -> busy=0 and resp_valid=0 immediately. After release, the next request 9/3 returns 3 granted to requester 0.
- Operand stability: requester changes req_dividend from 200 to 1 the cycle after its handshake (divisor 10) -> resp_quotient=20.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
//   state_t       : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   DIV0_QUOTIENT : all-ones pattern of a given width, returned for x/0
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Low 'width' bits set; callers cast down to their quotient width.
  function automatic logic [63:0] DIV0_QUOTIENT(input int width);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/div_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   i_req   : NUM_REQ request bits
//   i_ptr   : index with highest priority this cycle
//   o_grant : one-hot grant, zero when no request
//   o_idx   : encoded index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_idx
);

  logic                w_found;
  logic [ID_WIDTH-1:0] w_j;

  // Walk upward from i_ptr with wrap-around; first set request wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = ID_WIDTH'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/div_unsigned.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   valid_in       : one-cycle start strobe; operands sampled with it
//   dividend       : DIVIDEND_WIDTH unsigned dividend
//   divisor        : DIVISOR_WIDTH unsigned divisor (zero-extended internally)
//   valid_out      : one-cycle pulse when quotient is ready
//   quotient       : DIVIDEND_WIDTH unsigned result, valid with valid_out
// A divisor of 1 takes a fast path and answers the cycle after valid_in.
module div_unsigned #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      valid_out,
  output logic [DIVIDEND_WIDTH-1:0] quotient
);

  localparam int CNT_W = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;

  logic [DIVIDEND_WIDTH-1:0] r_q;
  logic [DIVISOR_WIDTH-1:0]  r_rem;
  logic [DIVISOR_WIDTH-1:0]  r_dvs;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_run;
  logic                      r_vld;
  logic [DIVISOR_WIDTH:0]    w_shift;
  logic [DIVISOR_WIDTH:0]    w_trial;

  // Partial remainder stays below the divisor, so one extra bit holds the shift.
  assign w_shift = {r_rem, r_q[DIVIDEND_WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (valid_in) begin
        r_q   <= dividend;
        r_rem <= '0;
        r_dvs <= divisor;
        r_cnt <= '0;
        if (divisor == DIVISOR_WIDTH'(1)) begin
          r_run <= 1'b0;
          r_vld <= 1'b1;
        end else begin
          r_run <= 1'b1;
        end
      end else if (r_run) begin
        // Dividend bits shift out of r_q's top while quotient bits enter its bottom.
        if (!w_trial[DIVISOR_WIDTH]) begin
          r_rem <= w_trial[DIVISOR_WIDTH-1:0];
          r_q   <= {r_q[DIVIDEND_WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[DIVISOR_WIDTH-1:0];
          r_q   <= {r_q[DIVIDEND_WIDTH-2:0], 1'b0};
        end
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(DIVIDEND_WIDTH - 1)) begin
          r_run <= 1'b0;
          r_vld <= 1'b1;
        end
      end
    end
  end

  assign valid_out = r_vld;
  assign quotient  = r_q;

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one div_unsigned among NUM_REQ requesters.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   req_valid      : per-requester request valid
//   req_ready      : per-requester accept (at most one bit, only in IDLE)
//   req_dividend   : packed dividends, slice i for requester i
//   req_divisor    : packed divisors, slice i for requester i
//   resp_valid     : one-hot one-cycle response pulse
//   resp_id        : ID of responding requester
//   resp_quotient  : quotient (all ones on divide-by-zero)
//   resp_div0      : divisor was zero
//   busy           : sequencer not in IDLE
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  DIVIDEND_WIDTH = 16,
  parameter int  DIVISOR_WIDTH  = 8,
  localparam int ID_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor,
  output logic [NUM_REQ-1:0]                resp_valid,
  output logic [ID_WIDTH-1:0]               resp_id,
  output logic [DIVIDEND_WIDTH-1:0]         resp_quotient,
  output logic                              resp_div0,
  output logic                              busy
);

  state_t                    r_state;
  logic [ID_WIDTH-1:0]       r_ptr;
  logic [ID_WIDTH-1:0]       r_id;
  logic [DIVIDEND_WIDTH-1:0] r_dividend;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  logic [DIVIDEND_WIDTH-1:0] r_quot;
  logic                      r_div0;
  logic [NUM_REQ-1:0]        r_resp_valid;
  logic                      r_busy;
  logic                      r_div_vld;

  logic [NUM_REQ-1:0]        w_grant;
  logic [ID_WIDTH-1:0]       w_idx;
  logic [ID_WIDTH-1:0]       w_ptr_nxt;
  logic                      w_hs;
  logic [DIVIDEND_WIDTH-1:0] w_sel_dividend;
  logic [DIVISOR_WIDTH-1:0]  w_sel_divisor;
  logic                      w_div_vout;
  logic [DIVIDEND_WIDTH-1:0] w_div_quot;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [ID_WIDTH-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign w_hs      = |(req_valid & req_ready);
  assign w_ptr_nxt = (w_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  // Operand mux on the granted slice.
  always_comb begin
    w_sel_dividend = '0;
    w_sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == ID_WIDTH'(i)) begin
        w_sel_dividend = req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        w_sel_divisor  = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      end
    end
  end

  div_unsigned #(
    .DIVIDEND_WIDTH (DIVIDEND_WIDTH),
    .DIVISOR_WIDTH  (DIVISOR_WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (~reset),
    .valid_in  (r_div_vld),
    .dividend  (r_dividend),
    .divisor   (r_divisor),
    .valid_out (w_div_vout),
    .quotient  (w_div_quot)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_quot       <= '0;
      r_div0       <= 1'b0;
      r_resp_valid <= '0;
      r_busy       <= 1'b0;
      r_div_vld    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_id       <= w_idx;
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
            r_ptr      <= w_ptr_nxt;
            r_busy     <= 1'b1;
            if (w_sel_divisor != '0) begin
              r_div0    <= 1'b0;
              r_div_vld <= 1'b1;
              r_state   <= ISSUE;
            end else begin
              // Zero divisor is answered locally; the divider never sees it.
              r_div0       <= 1'b1;
              r_quot       <= DIVIDEND_WIDTH'(DIV0_QUOTIENT(DIVIDEND_WIDTH));
              r_resp_valid <= f_onehot(w_idx);
              r_state      <= RESP;
            end
          end
        end
        ISSUE: begin
          r_div_vld <= 1'b0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (w_div_vout) begin
            r_quot       <= w_div_quot;
            r_resp_valid <= f_onehot(r_id);
            r_state      <= RESP;
          end
        end
        RESP: begin
          r_resp_valid <= '0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_id;
  assign resp_quotient = r_quot;
  assign resp_div0     = r_div0;
  assign busy          = r_busy;

endmodule

// File: tb/tb_div_share_arbiter.sv
module tb_div_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int VW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_dividend;
  logic [N*VW-1:0] req_divisor;
  logic [N-1:0]  resp_valid;
  logic [IW-1:0] resp_id;
  logic [DW-1:0] resp_quotient;
  logic          resp_div0;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;
  int vin_cnt  = 0;
  int m_ptr    = 0;

  logic [DW-1:0] dd_a [N];
  logic [VW-1:0] ds_a [N];

  div_share_arbiter #(.NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .resp_valid    (resp_valid),
    .resp_id       (resp_id),
    .resp_quotient (resp_quotient),
    .resp_div0     (resp_div0),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.r_div_vld) vin_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_ops();
    req_dividend = {dd_a[3], dd_a[2], dd_a[1], dd_a[0]};
    req_divisor  = {ds_a[3], ds_a[2], ds_a[1], ds_a[0]};
  endtask

  // Reference: first requester set in m, searching upward from p with wrap.
  function automatic int model_grant(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (((m >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] model_quot(input logic [DW-1:0] dd, input logic [VW-1:0] ds);
    if (ds == '0) return 16'hFFFF;
    return DW'(32'(dd) / 32'(ds));
  endfunction

  // Returns the index of the requester whose handshake happens at the next edge.
  task automatic wait_grant(output int g);
    logic [N-1:0] hs;
    g = -1;
    for (int c = 0; c < 200; c++) begin
      #1;
      hs = req_valid & req_ready;
      if (hs != '0) begin
        for (int i = 0; i < N; i++) if (((hs >> i) & 4'd1) != 4'd0 && g < 0) g = i;
        return;
      end
      step();
    end
  endtask

  // Entered in cycle 1 after a handshake; lat is the cycle resp_valid rises.
  task automatic await_resp(output int lat, output bit rdy_seen);
    lat = -1;
    rdy_seen = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      #1;
      if (resp_valid != '0) begin
        lat = c;
        return;
      end
      if (req_ready != '0) rdy_seen = 1'b1;
      step();
    end
  endtask

  task automatic run_one(input int id, input logic [DW-1:0] dd, input logic [VW-1:0] ds,
                         input logic [DW-1:0] dd_after, input bit keep, input int exp_lat,
                         input string tag);
    int g, lat, vs0;
    bit rdy;
    logic [DW-1:0] eq;
    eq = model_quot(dd, ds);
    dd_a[id] = dd;
    ds_a[id] = ds;
    apply_ops();
    req_valid = N'(1 << id);
    wait_grant(g);
    chk({tag, "_grant"}, 32'(g), 32'(id));
    m_ptr = (id + 1) % N;
    vs0 = vin_cnt;
    step();
    dd_a[id] = dd_after;
    apply_ops();
    if (!keep) req_valid = '0;
    await_resp(lat, rdy);
    req_valid = '0;
    chk({tag, "_done"}, 32'(lat > 0), 32'd1);
    if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'(1 << id));
    chk({tag, "_rid"}, 32'(resp_id), 32'(id));
    chk({tag, "_quot"}, 32'(resp_quotient), 32'(eq));
    chk({tag, "_div0"}, 32'(resp_div0), 32'(ds == '0));
    if (keep) chk({tag, "_ready_low"}, 32'(rdy), 32'd0);
    if (ds == '0) chk({tag, "_no_vin"}, 32'(vin_cnt - vs0), 32'd0);
    step();
    chk({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int g, eg, lat, cnt;
    bit rdy, dup;
    logic [N-1:0] mask;
    logic [DW-1:0] eq;
    logic [VW-1:0] eds;
    int hist[$];

    reset = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      dd_a[i] = '0;
      ds_a[i] = '0;
    end
    apply_ops();
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rid", 32'(resp_id), 32'd0);
    chk("rst_quot", 32'(resp_quotient), 32'd0);
    chk("rst_div0", 32'(resp_div0), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    step();

    // Round-robin with every requester asserting continuously.
    for (int i = 0; i < N; i++) begin
      dd_a[i] = 16'd30;
      ds_a[i] = 8'd3;
    end
    apply_ops();
    req_valid = 4'hF;
    for (int r = 0; r < 5; r++) begin
      wait_grant(g);
      eg = model_grant(4'hF, m_ptr);
      chk($sformatf("rr_grant%0d", r), 32'(g), 32'(eg));
      chk($sformatf("rr_order%0d", r), 32'(g), 32'(r % N));
      dup = 1'b0;
      for (int h = 0; h < hist.size(); h++) if (hist[h] == g) dup = 1'b1;
      if (hist.size() >= 3) chk($sformatf("rr_fair%0d", r), 32'(dup), 32'd0);
      hist.push_back(g);
      if (hist.size() > 3) void'(hist.pop_front());
      m_ptr = (eg + 1) % N;
      step();
      await_resp(lat, rdy);
      chk($sformatf("rr_done%0d", r), 32'(lat > 0), 32'd1);
      chk($sformatf("rr_quot%0d", r), 32'(resp_quotient), 32'd10);
      chk($sformatf("rr_rid%0d", r), 32'(resp_id), 32'(eg));
      if (r == 4) req_valid = '0;
    end
    step();

    run_one(0, 16'd100, 8'd7, 16'd100, 1'b1, -1, "single");
    run_one(2, 16'hBEEF, 8'd1, 16'h1234, 1'b0, 3, "div1");
    run_one(3, 16'd55, 8'd0, 16'd55, 1'b0, 1, "div0");
    run_one(1, 16'd200, 8'd10, 16'd1, 1'b0, -1, "stable");

    // Reset during a long division: nothing may come back for it.
    dd_a[1] = 16'hFFFF;
    ds_a[1] = 8'd2;
    apply_ops();
    req_valid = 4'b0010;
    wait_grant(g);
    chk("rstmid_grant", 32'(g), 32'd1);
    step();
    req_valid = '0;
    repeat (3) step();
    chk("rstmid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rvalid", 32'(resp_valid), 32'd0);
    chk("rstmid_quot", 32'(resp_quotient), 32'd0);
    m_ptr = 0;
    repeat (2) step();
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (resp_valid != '0) cnt++;
    end
    chk("rstmid_no_resp", 32'(cnt), 32'd0);
    for (int i = 0; i < N; i++) begin
      dd_a[i] = 16'd9;
      ds_a[i] = 8'd3;
    end
    apply_ops();
    req_valid = 4'hF;
    wait_grant(g);
    chk("rstmid_after_grant", 32'(g), 32'(model_grant(4'hF, m_ptr)));
    m_ptr = (g + 1) % N;
    step();
    req_valid = '0;
    await_resp(lat, rdy);
    chk("rstmid_after_done", 32'(lat > 0), 32'd1);
    chk("rstmid_after_quot", 32'(resp_quotient), 32'd3);
    chk("rstmid_after_rid", 32'(resp_id), 32'd0);
    step();

    // Randomized contention against the reference model.
    for (int t = 0; t < 24; t++) begin
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        int sel;
        dd_a[i] = DW'($urandom);
        sel = $urandom_range(0, 9);
        ds_a[i] = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : VW'($urandom);
      end
      apply_ops();
      req_valid = mask;
      eg = model_grant(mask, m_ptr);
      eq = model_quot(dd_a[eg], ds_a[eg]);
      eds = ds_a[eg];
      wait_grant(g);
      chk($sformatf("rnd%0d_grant", t), 32'(g), 32'(eg));
      chk($sformatf("rnd%0d_onehot", t), 32'($onehot(req_ready)), 32'd1);
      m_ptr = (eg + 1) % N;
      step();
      for (int i = 0; i < N; i++) begin
        dd_a[i] = DW'($urandom);
        ds_a[i] = VW'($urandom);
      end
      apply_ops();
      req_valid = '0;
      await_resp(lat, rdy);
      chk($sformatf("rnd%0d_done", t), 32'(lat > 0), 32'd1);
      if (eds == 8'd0) chk($sformatf("rnd%0d_lat0", t), 32'(lat), 32'd1);
      if (eds == 8'd1) chk($sformatf("rnd%0d_lat1", t), 32'(lat), 32'd3);
      chk($sformatf("rnd%0d_rvalid", t), 32'(resp_valid), 32'(1 << eg));
      chk($sformatf("rnd%0d_rid", t), 32'(resp_id), 32'(eg));
      chk($sformatf("rnd%0d_quot", t), 32'(resp_quotient), 32'(eq));
      chk($sformatf("rnd%0d_div0", t), 32'(resp_div0), 32'(eds == 8'd0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
